// File: rtl/teller_dispatcher.sv
// teller_dispatcher: round-robin "call next customer" controller for up to three tellers.
// Optional grant timeout with a missedCall pulse when DISPATCH_TIMEOUT_EN is defined.
module teller_dispatcher #(
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Tcount,
    input  logic       emptyFlag,
    input  logic [2:0] tellerReady,
    input  logic [2:0] tellerAck,
    output logic [2:0] grant,
    output logic       downSignal,
    output logic [1:0] callId,
    output logic       busy,
    output logic       cfgError,
    output logic       missedCall
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned NT    = 3;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    // Out-of-range parameters are reported the same way as an illegal teller count.
    localparam bit PARAMS_OK = (GAP_CYCLES >= 1) && (GAP_CYCLES <= 15) &&
                               (ACK_TIMEOUT >= 1) && (ACK_TIMEOUT <= 15);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_CALL, S_GAP} state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_winner, w_winner_nxt;
    logic [IDX_W-1:0]   r_last, w_last_nxt;
    logic [IDX_W-1:0]   r_call_id, w_call_id_nxt;
    logic [CNT_W-1:0]   r_gap_cnt, w_gap_cnt_nxt;
    logic [NT-1:0]      r_grant, w_grant_nxt;
    logic               r_down, w_down_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_cfg_error;
    logic [NT-1:0]      w_active, w_eligible, w_win_oh;
    logic [IDX_W-1:0]   w_c1, w_c2, w_pick;
    logic               w_win_ok;

`ifdef DISPATCH_TIMEOUT_EN
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
    logic [CNT_W-1:0]   r_ack_cnt, w_ack_cnt_nxt;
    logic               r_missed, w_missed_nxt;
`endif

    function automatic logic [NT-1:0] onehot(input logic [IDX_W-1:0] idx);
        case (idx)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            2'd2:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
    endfunction

    function automatic logic [IDX_W-1:0] succ(input logic [IDX_W-1:0] idx);
        succ = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Active-teller mask from the configured count.
    always_comb begin
        case (Tcount)
            2'd1:    w_active = 3'b001;
            2'd2:    w_active = 3'b011;
            2'd3:    w_active = 3'b111;
            default: w_active = 3'b000;
        endcase
    end

    assign w_eligible = tellerReady & w_active;
    assign w_c1       = succ(r_last);
    assign w_c2       = succ(w_c1);
    assign w_win_oh   = onehot(r_winner);
    assign w_win_ok   = |(w_win_oh & w_active & tellerReady);

    // Round-robin pick: the teller after last first, last itself at the back.
    always_comb begin
        if (|(w_eligible & onehot(w_c1))) begin
            w_pick = w_c1;
        end else if (|(w_eligible & onehot(w_c2))) begin
            w_pick = w_c2;
        end else begin
            w_pick = r_last;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_winner_nxt  = r_winner;
        w_last_nxt    = r_last;
        w_call_id_nxt = r_call_id;
        w_gap_cnt_nxt = r_gap_cnt;
        w_grant_nxt   = '0;
        w_down_nxt    = 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
        w_ack_cnt_nxt = r_ack_cnt;
        w_missed_nxt  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if ((Tcount != 2'd0) && !r_cfg_error && !emptyFlag && (|w_eligible)) begin
                    w_state_nxt  = S_GRANT;
                    w_winner_nxt = w_pick;
                    w_grant_nxt  = onehot(w_pick);
`ifdef DISPATCH_TIMEOUT_EN
                    w_ack_cnt_nxt = '0;
`endif
                end
            end
            S_GRANT: begin
                if (emptyFlag || !w_win_ok) begin
                    w_state_nxt = S_IDLE;
                end else if (|(tellerAck & w_win_oh)) begin
                    w_state_nxt   = S_CALL;
                    w_down_nxt    = 1'b1;
                    w_call_id_nxt = r_winner;
                    w_last_nxt    = r_winner;
`ifdef DISPATCH_TIMEOUT_EN
                end else if (r_ack_cnt == ACK_LAST) begin
                    // Unresponsive teller goes to the back of the rotation.
                    w_state_nxt  = S_IDLE;
                    w_missed_nxt = 1'b1;
                    w_last_nxt   = r_winner;
                end else begin
                    w_ack_cnt_nxt = r_ack_cnt + CNT_W'(1);
                    w_grant_nxt   = w_win_oh;
`else
                end else begin
                    w_grant_nxt = w_win_oh;
`endif
                end
            end
            S_CALL: begin
                w_state_nxt   = S_GAP;
                w_gap_cnt_nxt = '0;
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_winner    <= 2'd0;
            r_last      <= 2'd2;
            r_call_id   <= 2'd0;
            r_gap_cnt   <= '0;
            r_grant     <= '0;
            r_down      <= 1'b0;
            r_busy      <= 1'b0;
            r_cfg_error <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_winner    <= w_winner_nxt;
            r_last      <= w_last_nxt;
            r_call_id   <= w_call_id_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_grant     <= w_grant_nxt;
            r_down      <= w_down_nxt;
            r_busy      <= w_busy_nxt;
            r_cfg_error <= (Tcount == 2'd0) || !PARAMS_OK;
        end
    end

`ifdef DISPATCH_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack_cnt <= '0;
            r_missed  <= 1'b0;
        end else begin
            r_ack_cnt <= w_ack_cnt_nxt;
            r_missed  <= w_missed_nxt;
        end
    end
    assign missedCall = r_missed;
`else
    assign missedCall = 1'b0;
`endif

    assign grant      = r_grant;
    assign downSignal = r_down;
    assign callId     = r_call_id;
    assign busy       = r_busy;
    assign cfgError   = r_cfg_error;

endmodule

// File: tb/tb_teller_dispatcher.sv
// Bench for teller_dispatcher: directed scenarios with literal expectations plus random
// stimulus checked every cycle against a transaction-level model.
module tb_teller_dispatcher;
    localparam int unsigned GAP = 2;
    localparam int unsigned ATO = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] Tcount = 2'd3;
    logic       emptyFlag = 1'b1;
    logic [2:0] tellerReady = 3'b000;
    logic [2:0] tellerAck = 3'b000;
    logic [2:0] grant;
    logic       downSignal;
    logic [1:0] callId;
    logic       busy;
    logic       cfgError;
    logic       missedCall;

    int n_checks = 0;
    int n_errors = 0;

    teller_dispatcher #(.GAP_CYCLES(GAP), .ACK_TIMEOUT(ATO)) dut (
        .clk(clk), .reset(reset), .Tcount(Tcount), .emptyFlag(emptyFlag),
        .tellerReady(tellerReady), .tellerAck(tellerAck), .grant(grant),
        .downSignal(downSignal), .callId(callId), .busy(busy),
        .cfgError(cfgError), .missedCall(missedCall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: owner = teller holding an outstanding offer (-1 none); hold = edges left
    // before the next arbitration is allowed after a call.
    int m_owner = -1;
    int m_wait = 0;
    int m_hold = 0;
    int m_last = 2;
    int m_callid = 0;
    bit m_down = 1'b0;
    bit m_missed = 1'b0;
    bit m_cfg = 1'b0;

    always @(posedge clk or posedge reset) begin
        int idx;
        bit found;
        if (reset) begin
            m_owner = -1; m_wait = 0; m_hold = 0; m_last = 2; m_callid = 0;
            m_down = 1'b0; m_missed = 1'b0; m_cfg = 1'b0;
        end else begin
            m_down = 1'b0;
            m_missed = 1'b0;
            if (m_owner >= 0) begin
                if (emptyFlag || m_owner >= int'(Tcount) || !tellerReady[m_owner]) begin
                    m_owner = -1;
                end else if (tellerAck[m_owner]) begin
                    m_down = 1'b1;
                    m_callid = m_owner;
                    m_last = m_owner;
                    m_owner = -1;
                    m_hold = GAP + 1;
`ifdef DISPATCH_TIMEOUT_EN
                end else if (m_wait + 1 == ATO) begin
                    m_missed = 1'b1;
                    m_last = m_owner;
                    m_owner = -1;
`endif
                end else begin
                    m_wait++;
                end
            end else if (m_hold > 0) begin
                m_hold--;
            end else if (Tcount != 2'd0 && !m_cfg && !emptyFlag) begin
                found = 1'b0;
                for (int s = 1; s <= 3; s++) begin
                    idx = (m_last + s) % 3;
                    if (!found && idx < int'(Tcount) && tellerReady[idx]) begin
                        m_owner = idx;
                        m_wait = 0;
                        found = 1'b1;
                    end
                end
            end
            m_cfg = (Tcount == 2'd0);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        int eg;
        eg = (m_owner >= 0) ? (1 << m_owner) : 0;
        chk("m_grant", int'(grant), eg);
        chk("m_down", int'(downSignal), int'(m_down));
        chk("m_callid", int'(callId), m_callid);
        chk("m_busy", int'(busy), int'(m_owner >= 0 || m_hold > 0));
        chk("m_cfg", int'(cfgError), int'(m_cfg));
        chk("m_missed", int'(missedCall), int'(m_missed));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] exp_g;
    logic [2:0] rr_seq [4];

    initial begin
        rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100; rr_seq[3] = 3'b001;
        repeat (3) tick();
        chk("rst_grant", int'(grant), 0);
        chk("rst_down", int'(downSignal), 0);
        chk("rst_callid", int'(callId), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cfg", int'(cfgError), 0);
        chk("rst_missed", int'(missedCall), 0);
        reset = 1'b0;

        // Round robin with immediate acks: spacing GAP+3 edges.
        Tcount = 2'd3; emptyFlag = 1'b0; tellerReady = 3'b111; tellerAck = 3'b111;
        tick();
        for (int c = 0; c < 4; c++) begin
            chk("rr_grant", int'(grant), int'(rr_seq[c]));
            chk("rr_busy", int'(busy), 1);
            tick();
            chk("rr_down", int'(downSignal), 1);
            chk("rr_callid", int'(callId), c % 3);
            chk("rr_grant_off", int'(grant), 0);
            if (c == 3) begin
                tellerReady = 3'b000; tellerAck = 3'b000;
                repeat (5) tick();
            end else begin
                repeat (4) tick();
            end
        end

        // Active mask: only teller 0 may be served with Tcount=1.
        Tcount = 2'd1; tellerReady = 3'b110;
        repeat (3) tick();
        chk("mask_nogrant", int'(grant), 0);
        chk("mask_busy", int'(busy), 0);
        tellerReady = 3'b111;
        tick();
        chk("mask_grant", int'(grant), 1);
        tellerAck = 3'b001;
        tick();
        chk("mask_down", int'(downSignal), 1);
        tellerAck = 3'b000; tellerReady = 3'b000;
        repeat (4) tick();

        // Abandon on empty queue; the same teller wins again.
        Tcount = 2'd3; tellerReady = 3'b010;
        tick();
        chk("ab_grant", int'(grant), 2);
        emptyFlag = 1'b1;
        tick();
        chk("ab_drop", int'(grant), 0);
        chk("ab_nodown", int'(downSignal), 0);
        chk("ab_busy", int'(busy), 0);
        emptyFlag = 1'b0; tellerReady = 3'b111;
        tick();
        chk("ab_regrant", int'(grant), 2);
        tellerAck = 3'b010;
        tick();
        chk("ab_down", int'(downSignal), 1);
        chk("ab_callid", int'(callId), 1);

        // Illegal teller count.
        tellerAck = 3'b000; Tcount = 2'd0;
        tick();
        chk("cfg_set", int'(cfgError), 1);
        repeat (6) tick();
        chk("cfg_nogrant", int'(grant), 0);
        chk("cfg_idle", int'(busy), 0);
        chk("cfg_hold", int'(cfgError), 1);
        Tcount = 2'd2;
        tick();
        chk("cfg_clear", int'(cfgError), 0);
        chk("cfg_wait", int'(grant), 0);
        tick();
        chk("cfg_resume", int'(grant), 1);

`ifdef DISPATCH_TIMEOUT_EN
        repeat (14) tick();
        chk("to_pending", int'(grant), 1);
        chk("to_nomiss", int'(missedCall), 0);
        tick();
        chk("to_missed", int'(missedCall), 1);
        chk("to_grant_off", int'(grant), 0);
        chk("to_nodown", int'(downSignal), 0);
        tick();
        chk("to_next", int'(grant), 2);
        chk("to_pulse1", int'(missedCall), 0);
        exp_g = 3'b010;
`else
        repeat (120) tick();
        chk("hold_grant", int'(grant), 1);
        chk("hold_missed", int'(missedCall), 0);
        chk("hold_nodown", int'(downSignal), 0);
        exp_g = 3'b001;
`endif

        // Reset during CALL, then during GRANT.
        tellerAck = exp_g;
        tick();
        chk("rc_down", int'(downSignal), 1);
        #1 reset = 1'b1;
        #1;
        chk("rc_down0", int'(downSignal), 0);
        chk("rc_grant0", int'(grant), 0);
        chk("rc_busy0", int'(busy), 0);
        chk("rc_callid0", int'(callId), 0);
        @(negedge clk);
        reset = 1'b0; tellerAck = 3'b000; Tcount = 2'd3; tellerReady = 3'b111;
        tick();
        chk("rg_first", int'(grant), 1);
        #1 reset = 1'b1;
        #1;
        chk("rg_grant0", int'(grant), 0);
        chk("rg_busy0", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("rg_again", int'(grant), 1);

        // Random traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) Tcount = 2'($urandom_range(0, 3));
            emptyFlag = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) tellerReady = 3'($urandom);
            tellerAck = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
        end
        reset = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/teller_dispatcher.md
# teller_dispatcher

Clocked controller that calls the next customer from the single-bank queue to a free teller. It arbitrates round-robin among up to three tellers (active count `Tcount`), runs a grant/acknowledge handshake with the selected teller, and then issues a one-cycle `downSignal` pulse to the queue counter. It sits between the teller desks and the queue-management block, taking `emptyFlag` from it and driving its front-sensor input.

## Interface
- `GAP_CYCLES`, 2: idle cycles after each call before the next arbitration, so the queue count and flags settle; range 1..15.
- `ACK_TIMEOUT`, 15: cycles a grant waits for acknowledge before it is abandoned; range 1..15; used only with `DISPATCH_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `Tcount` in 2: number of active tellers; teller i is active when i < `Tcount`; 0 is illegal.
- `emptyFlag` in 1: queue empty, from the queue block.
- `tellerReady` in 3: per-teller level, desk free to accept a customer.
- `tellerAck` in 3: per-teller level, accepts the outstanding grant.
- `grant` out 3: one-hot offer to the selected teller.
- `downSignal` out 1: one-cycle pulse, removes one person from the queue.
- `callId` out 2: index (0..2) of the teller most recently served.
- `busy` out 1: high in any state except IDLE.
- `cfgError` out 1: registered `Tcount == 0`.
- `missedCall` out 1: one-cycle pulse on grant timeout; tied 0 without the macro.

## Operation
- Reset values: state IDLE, `grant`=0, `downSignal`=0, `callId`=0, `busy`=0, `cfgError`=0, `missedCall`=0, round-robin pointer `last`=2 (teller 0 wins first).
- Eligible set = `tellerReady` & active mask (`Tcount`: 1→001, 2→011, 3→111, 0→000).
- IDLE → GRANT when `Tcount`≠0, `emptyFlag`=0 and the eligible set is non-zero.
  - Winner is the first eligible index in the order `last`+1, `last`+2, `last`+3 (mod 3).
  - The winner is registered; `grant` is the Moore decode of GRANT plus the winner.
- GRANT exits, in priority order:
  - `emptyFlag`=1, winner no longer active, or winner's `tellerReady`=0 → IDLE; no pulse; `last` unchanged.
  - `tellerAck`[winner]=1 → CALL.
  - Timeout (macro only) → IDLE.
  - Otherwise stay in GRANT.
  - `tellerAck` bits of non-granted tellers are ignored.
- CALL (exactly 1 cycle):
  - `downSignal`=1, `grant`=0.
  - `callId` and `last` are loaded with the winner.
  - Next state is GAP.
- GAP: counts `GAP_CYCLES` cycles, then → IDLE. Inputs are ignored.
- `cfgError` updates every cycle. While it is set, IDLE never leaves, and other states complete normally.
- At most one `downSignal` per handshake. `downSignal` is never asserted while `emptyFlag` was 1 on the preceding edge.

## Timing
- Request seen at edge k → `grant` high from edge k.
- Ack sampled at edge m → `downSignal` high for the single cycle after edge m.
- `callId` is valid from edge m.
- Minimum call-to-call spacing is `GAP_CYCLES`+3 cycles (GRANT 1, CALL 1, GAP, IDLE 1) with same-cycle ack.
- Async `reset` mid-handshake clears `grant` and `downSignal` immediately; no partial pulse survives.
- A `Tcount` change takes effect on the next arbitration. A granted teller that becomes inactive is dropped at the next edge.

## Configuration
- `DISPATCH_TIMEOUT_EN` defined:
  - A 4-bit counter runs in GRANT.
  - After `ACK_TIMEOUT` cycles without ack, the block pulses `missedCall` for 1 cycle and returns to IDLE.
  - `last` is set to the winner, so the unresponsive teller goes to the back of the rotation.
- `DISPATCH_TIMEOUT_EN` undefined:
  - GRANT waits indefinitely, subject only to the abandon conditions.
  - `missedCall` is constant 0 and no counter is built.

## Test plan
- Round-robin: reset, `Tcount`=3, `tellerReady`=111, `emptyFlag`=0, ack each grant at once → grants 001, 010, 100, 001; one `downSignal` each; `callId` 0,1,2,0; spacing 5 cycles with `GAP_CYCLES`=2.
- Active mask: `Tcount`=1, `tellerReady`=110 → no grant, `busy`=0; then `tellerReady`=111 → `grant`=001.
- Abandon: grant teller 1, then `emptyFlag`=1 before ack → `grant` clears next edge, no `downSignal`, the next winner is again teller 1.
- Illegal config: `Tcount`=0 with a non-empty queue and all ready → `cfgError`=1 after 1 edge, no grants; `Tcount`=2 → grants resume.
- Timeout (macro on, `ACK_TIMEOUT`=15): grant teller 0 with no ack → after 15 cycles `missedCall` pulses once, no `downSignal`, the next grant goes to teller 1. Macro off: `grant` held 100+ cycles.
- Reset mid-handshake: assert `reset` during GRANT or CALL → all outputs 0 within the same cycle; after release the first grant goes to teller 0.
